// File: rtl/seg7_pkg.sv
// Glyph set, segment encodings and display range limits for the seven-segment driver.
package seg7_pkg;

  typedef enum logic [3:0] {
    D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
    BLANK, MINUS, E, R
  } glyph_e;

  localparam int BCD_W = 4;
  localparam logic signed [15:0] MAX_VAL = 16'sd9999;
  localparam logic signed [15:0] MIN_VAL = -16'sd999;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph_to_seg(input glyph_e g);
    case (g)
      D0:      return 7'b1000000;
      D1:      return 7'b1111001;
      D2:      return 7'b0100100;
      D3:      return 7'b0110000;
      D4:      return 7'b0011001;
      D5:      return 7'b0010010;
      D6:      return 7'b0000010;
      D7:      return 7'b1111000;
      D8:      return 7'b0000000;
      D9:      return 7'b0010000;
      MINUS:   return 7'b0111111;
      E:       return 7'b0000110;
      R:       return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16 shift/add-3 iterations, one per cycle, after a start pulse.
// done_o is high during the final iteration; bcd_o is valid the cycle after.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic        done_o,
  output logic [15:0] bcd_o
);

  logic [15:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] adj;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [3:0]  nib;

  always_comb begin
    adj = '0;
    nib = '0;
    for (int i = 0; i < 4; i++) begin
      nib = bcd_q[i*BCD_W +: BCD_W];
      adj[i*BCD_W +: BCD_W] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == 4'd15);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_display_driver.sv
// Captures a signed result on load, converts it to decimal glyphs and scans a
// 4-digit common-anode display; glyphs update atomically at the end of a conversion.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic signed [15:0] value_i,
  input  logic               load_i,
  output logic               busy_o,
  output logic [3:0]         an_o,
  output logic [6:0]         seg_o,
  output logic               dp_o
);

  localparam int TW = $clog2(DIGIT_TICKS);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  state_e      state_q, state_d;
  glyph_e      glyph_q [4];
  glyph_e      glyph_d [4];
  glyph_e      commit_g [4];
  logic        neg_q, oor_q;
  logic        start;
  logic        bcd_done;
  logic [15:0] bcd;
  logic [15:0] mag;
  logic [1:0]  msd;
  logic [TW-1:0] tick_q;
  logic [1:0]  idx_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;

  assign mag = value_i[15] ? (~value_i + 16'd1) : value_i;

  bin2bcd_seq u_bcd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start),
    .bin_i   (mag),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  // Sign goes one position left of the most significant shown digit.
  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < 4; i++)
      if (bcd[i*BCD_W +: BCD_W] != 4'd0) msd = 2'(i);
    for (int i = 0; i < 4; i++)
      commit_g[i] = (i <= int'(msd)) ? glyph_e'(bcd[i*BCD_W +: BCD_W]) : BLANK;
    if (neg_q && msd != 2'd3) commit_g[msd + 2'd1] = MINUS;
    if (oor_q) begin
      commit_g[3] = E;
      commit_g[2] = R;
      commit_g[1] = R;
      commit_g[0] = BLANK;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    glyph_d = glyph_q;
    case (state_q)
      IDLE: if (load_i) begin
        start   = 1'b1;
        state_d = CONV;
      end
      CONV: if (bcd_done) state_d = COMMIT;
      COMMIT: begin
        glyph_d = commit_g;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      oor_q   <= 1'b0;
      for (int i = 0; i < 4; i++) glyph_q[i] <= BLANK;
    end else begin
      state_q <= state_d;
      glyph_q <= glyph_d;
      if (start) begin
        neg_q <= value_i[15];
        oor_q <= (value_i > MAX_VAL) || (value_i < MIN_VAL);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
    end else begin
      if (tick_q == TW'(DIGIT_TICKS - 1)) begin
        tick_q <= '0;
        idx_q  <= idx_q + 2'd1;
      end else begin
        tick_q <= tick_q + TW'(1);
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= glyph_to_seg(glyph_q[idx_q]);
    end
  end

  assign busy_o = (state_q != IDLE);
  assign an_o   = an_q;
  assign seg_o  = seg_q;
  assign dp_o   = 1'b1;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Randomized and directed bench for seg7_display_driver against a decimal-string display model.
module tb_seg7_display_driver;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] value;
  logic               load;
  logic               busy;
  logic [3:0]         an;
  logic [6:0]         seg;
  logic               dp;

  int tests = 0;
  int fails = 0;

  seg7_display_driver #(.DIGIT_TICKS(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .value_i (value),
    .load_i  (load),
    .busy_o  (busy),
    .an_o    (an),
    .seg_o   (seg),
    .dp_o    (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected {digit3,digit2,digit1,digit0} from the decimal text of v.
  function automatic logic [27:0] model(input int v);
    logic [27:0] r;
    int mag, nd, t;
    if (v > 9999 || v < -999)
      return {7'b0000110, 7'b0101111, 7'b0101111, 7'b1111111};
    mag = (v < 0) ? -v : v;
    nd = 1;
    t = mag / 10;
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    t = mag;
    for (int p = 0; p < 4; p++) begin
      if (p < nd) r[p*7 +: 7] = digit_seg(t % 10);
      else if (v < 0 && p == nd) r[p*7 +: 7] = 7'b0111111;
      else r[p*7 +: 7] = 7'b1111111;
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; returns in the first cycle busy is low.
  task automatic do_load(input int v, output int n);
    value = v[15:0];
    load  = 1'b1;
    tick();
    load  = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic capture(output logic [27:0] shown);
    shown = '0;
    for (int c = 0; c < 16; c++) begin
      tick();
      case (an)
        4'b1110: shown[0  +: 7] = seg;
        4'b1101: shown[7  +: 7] = seg;
        4'b1011: shown[14 +: 7] = seg;
        4'b0111: shown[21 +: 7] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; value = '0;
    tick(); tick();
    tests++;
    if (busy !== 1'b0 || an !== 4'b1111 || seg !== 7'h7f || dp !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got busy=%b an=%b seg=%b dp=%b want 0 1111 1111111 1", busy, an, seg, dp);
    end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] exp_an;
      tick();
      exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
      tests++;
      if (an !== exp_an || seg !== 7'h7f || busy !== 1'b0 || dp !== 1'b1) begin
        fails++;
        $display("FAIL scan_after_reset k=%0d: got an=%b seg=%b busy=%b want an=%b seg=1111111 busy=0", k, an, seg, busy, exp_an);
      end
    end
  endtask

  task automatic test_directed();
    int vals [8] = '{1234, -42, 0, -999, 9999, -1, 10, -305};
    int n;
    logic [27:0] shown, exp;
    for (int i = 0; i < 8; i++) begin
      do_load(vals[i], n);
      tests++;
      if (n !== 17) begin
        fails++;
        $display("FAIL directed_busy v=%0d: got %0d cycles want 17", vals[i], n);
      end
      capture(shown);
      exp = model(vals[i]);
      for (int d = 0; d < 4; d++) begin
        tests++;
        if (shown[d*7 +: 7] !== exp[d*7 +: 7]) begin
          fails++;
          $display("FAIL directed v=%0d digit%0d: got %b want %b", vals[i], d, shown[d*7 +: 7], exp[d*7 +: 7]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int vals [4] = '{10000, -1000, -32768, 32767};
    int n;
    logic [27:0] shown, exp;
    for (int i = 0; i < 4; i++) begin
      do_load(vals[i], n);
      tests++;
      if (n !== 17) begin
        fails++;
        $display("FAIL overflow_busy v=%0d: got %0d cycles want 17", vals[i], n);
      end
      capture(shown);
      exp = model(vals[i]);
      tests++;
      if (shown !== exp) begin
        fails++;
        $display("FAIL overflow v=%0d: got %h want %h", vals[i], shown, exp);
      end
    end
  endtask

  task automatic test_random();
    int n, v, sel;
    logic [15:0] r16;
    logic [27:0] shown, exp;
    for (int i = 0; i < 12; i++) begin
      sel = $urandom_range(0, 3);
      r16 = 16'($urandom);
      case (sel)
        0: v = $urandom_range(0, 9999);
        1: v = -int'($urandom_range(1, 999));
        2: v = int'($signed(r16));
        default: v = $urandom_range(0, 99);
      endcase
      do_load(v, n);
      capture(shown);
      exp = model(v);
      tests++;
      if (n !== 17 || shown !== exp) begin
        fails++;
        $display("FAIL random v=%0d: got busy=%0d disp=%h want busy=17 disp=%h", v, n, shown, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic [27:0] shown;
    do_load(4321, n1);
    do_load(-7, n2);
    tests++;
    if (n1 !== 17 || n2 !== 17) begin
      fails++;
      $display("FAIL back_to_back_busy: got %0d,%0d want 17,17", n1, n2);
    end
    capture(shown);
    tests++;
    if (shown !== model(-7)) begin
      fails++;
      $display("FAIL back_to_back_disp: got %h want %h", shown, model(-7));
    end
  endtask

  task automatic test_ignore_load();
    int n;
    logic [27:0] shown;
    value = 16'd1234;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    value = 16'd5678;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    n = 5;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    tests++;
    if (n !== 17) begin
      fails++;
      $display("FAIL ignore_load_busy: got %0d want 17", n);
    end
    capture(shown);
    tests++;
    if (shown !== model(1234)) begin
      fails++;
      $display("FAIL ignore_load_disp: got %h want %h", shown, model(1234));
    end
  endtask

  task automatic test_reset_abort();
    logic [27:0] shown;
    value = 16'd5678;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || an !== 4'b1111 || seg !== 7'h7f) begin
      fails++;
      $display("FAIL reset_abort: got busy=%b an=%b seg=%b want 0 1111 1111111", busy, an, seg);
    end
    capture(shown);
    tests++;
    if (shown !== {4{7'h7f}} || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort_blank: got %h busy=%b want %h busy=0", shown, busy, {4{7'h7f}});
    end
    value = 16'd1234;
    rst  = 1'b1;
    load = 1'b1;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_wins_load: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_random();
    test_back_to_back();
    test_ignore_load();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_display_driver.md
# seg7_display_driver

Output-side counterpart to the pushbutton debouncer: where the debouncer turns a noisy human input into a clean single-cycle pulse, this block turns a calculator result into a stable human-readable output. On a single-cycle `load` pulse it captures a signed 16-bit result and converts it to decimal with a sequential double-dabble. It then drives a 4-digit, common-anode, multiplexed seven-segment display, including sign, leading-zero blanking and an "Err" overflow indication. It sits between the calculator datapath and the board display pins.

## Interface
- `DIGIT_TICKS`, default 100000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range ≥ 2.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `value`  in  16  signed two's-complement result to display.
- `load`  in  1  single-cycle capture strobe (e.g. a debounced "=" press).
- `busy`  out  1  high while a conversion is in progress.
- `an`  out  4  digit anodes, active-low, one-hot; `an[0]` is the rightmost digit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low; held at 1 (off).

## Operation
- Conversion FSM has three states: IDLE, CONV, COMMIT.
- **IDLE**
  - On `load`=1, latch `value`.
  - Compute the sign and the 16-bit magnitude.
  - Flag out-of-range if `value` > 9999 or `value` < -999.
  - Go to CONV.
- **CONV**
  - Run 16 shift/add-3 iterations, one per cycle, into a 16-bit BCD register (4 nibbles).
  - Runs the full 16 iterations even when the value is out of range, so latency is uniform.
- **COMMIT** writes the four glyph registers in one cycle, then returns to IDLE.
  - Out of range: glyphs, digit3 to digit0, are E, r, r, blank.
  - In range: zero digits left of the most significant non-zero digit are blanked.
  - Digit0 is never blanked, so a value of 0 shows "   0".
  - Negative values place a minus in the digit immediately left of the most significant shown digit. -999 fills digit3 with the minus.
- `load` while `busy`=1 is ignored; there is no queueing.
- Scanner runs continuously, independent of the FSM.
  - Tick counter counts 0..DIGIT_TICKS-1; on wrap the 2-bit digit index increments, 3 wraps to 0.
  - `an` = ~(1 << index).
  - `seg` = glyph encoding of glyph[index].
- Glyph encodings, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - minus = 0111111, E = 0000110, r = 0101111, blank = 1111111

## Timing
- Reset values:
  - `busy`=0, `an`=1111, `seg`=1111111, `dp`=1.
  - All glyphs blank; tick counter 0; digit index 0; FSM in IDLE.
- First cycle after reset deasserts: `an`=1110 and `seg`=blank.
- `an` and `seg` are registered: one cycle behind the index and glyph registers.
- Conversion timeline, with `load` sampled at cycle 0:
  - `busy`=1 in cycles 1–17.
  - Glyph registers hold the new value from cycle 18, when `busy` is back to 0.
  - `seg` shows the new glyph one cycle after the digit is selected.
- `load` sampled in the same cycle `busy` falls (cycle 18) is accepted.
- Glyph registers change only in COMMIT, so the display never shows a partial conversion.
- `rst` during CONV aborts the conversion and returns every register to its reset value.
- `rst` and `load` in the same cycle: reset wins and `load` is dropped.
- Digit dwell is exactly DIGIT_TICKS cycles; full refresh period is 4·DIGIT_TICKS.

## Structure
- Package `seg7_pkg` holds:
  - glyph enum (D0..D9, BLANK, MINUS, E, R)
  - `glyph_to_seg` constant function
  - range limits 9999 and -999
  - BCD digit width (4)
- Sub-module `bin2bcd_seq`:
  - Ports: 16-bit magnitude in, `start`, `done`, 16-bit BCD out.
  - Contains the iteration counter and the shift/add-3 datapath.
- Top level holds the range check, sign/blanking logic, glyph registers and scanner.

## Test plan
- Reset, then DIGIT_TICKS=4 → `an` cycles 1110, 1101, 1011, 0111 every 4 cycles; `seg`=1111111 throughout; `busy`=0.
- `load` with `value`=1234 → `busy` high for exactly 17 cycles; digits 3..0 show 0110000 (3)... read as "1234", i.e. digit3=1111001, digit2=0100100, digit1=0110000, digit0=0011001.
- `value`=-42 → digit3 blank, digit2=0111111, digit1=0011001, digit0=0100100.
- `value`=0 → "   0"; `value`=-999 → minus on digit3 followed by 9, 9, 9.
- `value`=10000, then -1000, then -32768 → each shows E, r, r, blank with the same 17-cycle `busy`.
- Second `load` with 5678 at cycle 5 of a 1234 conversion → ignored, "1234" shown. `rst` at cycle 9 of a fresh conversion → `busy`=0 and display blank the next cycle.
